// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Clock cycles per oversample tick, truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Received-byte stream between the UART front end and the SoC UART core.
// RX_DATA is valid whenever RX_VALID=1; a byte moves on any rising edge with RX_VALID && RX_READY.
interface uart_rx_frontend_if #(
    parameter int FIFO_DEPTH = 16
);
    logic [7:0]                    RX_DATA;
    logic                          RX_VALID;
    logic                          RX_READY;
    logic [$clog2(FIFO_DEPTH):0]   RX_LEVEL;

    modport master (
        output RX_DATA,
        output RX_VALID,
        output RX_LEVEL,
        input  RX_READY
    );

    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        input  RX_LEVEL,
        output RX_READY
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through read; a push while full is accepted only if a pop frees a slot.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads as zero when empty so the output is defined after reset.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: pin synchronizer, 16x oversampling deserializer FSM and receive FIFO.
module uart_rx_frontend
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 UART_RX,
    input  logic                 ERR_CLR,
    output logic                 RX_BUSY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output rx_state_t            dbg_state,
    uart_rx_frontend_if.master   rx
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [1:0]       sync_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [3:0]       samp_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             samp_mid;
    logic             samp_end;
    logic             samp_clr;
    logic             shift_en;
    logic             push;
    logic             pop;
    logic             frame_err_set;
    logic             overrun_set;
    logic             fifo_full;
    logic             fifo_empty;

    // Idle-high preset keeps a reset release from looking like a start bit.
    always_ff @(posedge CLK) begin
        if (!RST_N) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], UART_RX};
    end
    assign rx_s = sync_q[1];

    assign tick = (div_cnt == DIV_W'(DIV - 1));
    always_ff @(posedge CLK) begin
        if (!RST_N || tick) div_cnt <= '0;
        else                div_cnt <= div_cnt + 1'b1;
    end

    assign samp_mid = tick && (samp_cnt == 4'(OVERSAMPLE / 2 - 1));
    assign samp_end = tick && (samp_cnt == 4'(OVERSAMPLE - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (tick && !rx_s) state_d = START;
            START:     if (samp_mid) state_d = rx_s ? IDLE : DATA;
            DATA:      if (samp_end && bit_cnt == 3'd7) state_d = STOP;
            STOP:      if (samp_end) state_d = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (tick && rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        samp_clr      = 1'b0;
        shift_en      = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            IDLE:    samp_clr = tick & ~rx_s;
            START:   samp_clr = samp_mid & ~rx_s;
            DATA:    shift_en = samp_end;
            STOP: begin
                push          = samp_end & rx_s;
                frame_err_set = samp_end & ~rx_s;
            end
            default: ;
        endcase
    end

    assign RX_BUSY   = (state_q != IDLE);
    assign dbg_state = state_q;

    // Bits enter at the MSB so the first (LSB) bit ends up in bit 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else if (tick) begin
            samp_cnt <= samp_clr ? 4'd0 : samp_cnt + 1'b1;
            if (samp_clr)      bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)      shift_q <= {rx_s, shift_q[7:1]};
        end
    end

    assign pop         = rx.RX_VALID & rx.RX_READY;
    assign overrun_set = push & fifo_full & ~pop;

    // A new error in the clearing cycle keeps the flag set.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= frame_err_set | (FRAME_ERR & ~ERR_CLR);
            OVERRUN   <= overrun_set | (OVERRUN & ~ERR_CLR);
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .rd_data   (rx.RX_DATA),
        .level     (rx.RX_LEVEL),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx.RX_VALID = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: serial frames driven on the pin, bytes checked against a queue model.
module tb_uart_rx_frontend;
    import uart_rx_pkg::*;

    localparam int CLK_HZ   = 100_000_000;
    localparam int BAUD     = 1_562_500;
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_HZ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV;
    localparam int BIT_NS   = BIT_CLKS * 10;

    logic      CLK = 1'b0;
    logic      RST_N = 1'b0;
    logic      UART_RX = 1'b1;
    logic      ERR_CLR = 1'b0;
    logic      RX_BUSY;
    logic      FRAME_ERR;
    logic      OVERRUN;
    rx_state_t dbg_state;

    uart_rx_frontend_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

    uart_rx_frontend #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .UART_RX   (UART_RX),
        .ERR_CLR   (ERR_CLR),
        .RX_BUSY   (RX_BUSY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .dbg_state (dbg_state),
        .rx        (rx_if)
    );

    // Clock and watchdog
    initial forever #5 CLK = ~CLK;

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: expected FIFO contents and sticky flags
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       exp_frame_err = 1'b0;
    logic       exp_overrun   = 1'b0;

    function automatic void model_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit)                 exp_frame_err = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                           exp_overrun = 1'b1;
    endfunction

    // Driver tasks
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        UART_RX = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            #(BIT_NS);
        end
        UART_RX = stop_bit;
        #(BIT_NS);
        UART_RX = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] d, output logic v);
        @(negedge CLK);
        v = rx_if.RX_VALID;
        d = rx_if.RX_DATA;
        rx_if.RX_READY = 1'b1;
        @(negedge CLK);
        rx_if.RX_READY = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
    endtask

    task automatic wait_state(input rx_state_t s, input logic want_eq, output logic ok);
        int n = 0;
        while (((dbg_state == s) != want_eq) && n < 20 * BIT_CLKS) begin
            @(negedge CLK);
            n++;
        end
        ok = ((dbg_state == s) == want_eq);
    endtask

    // Scenarios
    task automatic test_reset();
        RST_N = 1'b0;
        repeat (5) @(negedge CLK);
        total++; if (rx_if.RX_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_if.RX_VALID); end
        total++; if (rx_if.RX_LEVEL !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", rx_if.RX_LEVEL); end
        total++; if (rx_if.RX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_if.RX_DATA); end
        total++; if ({RX_BUSY, FRAME_ERR, OVERRUN} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {RX_BUSY, FRAME_ERR, OVERRUN}); end
        RST_N = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge CLK);
        total++; if (dbg_state !== IDLE || RX_BUSY !== 1'b0) begin bad++; $display("FAIL reset_idle: got %s/%b want IDLE/0", dbg_state.name(), RX_BUSY); end
    endtask

    task automatic test_single_byte();
        logic ok1, ok2, vld;
        logic [7:0] d;
        logic v;
        rx_if.RX_READY = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_state(STOP, 1'b1, ok1);
                wait_state(STOP, 1'b0, ok2);
                vld = rx_if.RX_VALID;
            end
        join
        model_frame(8'hA5, 1'b1);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL single_stop_seen: got %b%b want 11", ok1, ok2); end
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL single_valid_latency: got %b want 1", vld); end
        @(negedge CLK);
        total++; if (rx_if.RX_DATA !== exp_q[0]) begin bad++; $display("FAIL single_data: got %h want %h", rx_if.RX_DATA, exp_q[0]); end
        total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size())) begin bad++; $display("FAIL single_level: got %0d want %0d", rx_if.RX_LEVEL, exp_q.size()); end
        total++; if (FRAME_ERR !== exp_frame_err) begin bad++; $display("FAIL single_frame_err: got %b want %b", FRAME_ERR, exp_frame_err); end
        while (exp_q.size() > 0) begin
            pop_byte(d, v);
            total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL single_pop: got %b/%h want 1/%h", v, d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h55};
        logic [7:0] d;
        logic v;
        for (int i = 0; i < 3; i++) begin
            send_frame(bytes[i], 1'b1);
            model_frame(bytes[i], 1'b1);
        end
        @(negedge CLK);
        total++; if (RX_BUSY !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b want 0", RX_BUSY); end
        total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size())) begin bad++; $display("FAIL b2b_level: got %0d want %0d", rx_if.RX_LEVEL, exp_q.size()); end
        while (exp_q.size() > 0) begin
            pop_byte(d, v);
            total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL b2b_pop: got %b/%h want 1/%h", v, d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        @(negedge CLK);
        total++; if (rx_if.RX_LEVEL !== 5'd0) begin bad++; $display("FAIL b2b_level_end: got %0d want 0", rx_if.RX_LEVEL); end
    endtask

    task automatic test_glitch();
        UART_RX = 1'b0;
        #200;
        total++; if (RX_BUSY !== 1'b1) begin bad++; $display("FAIL glitch_start_seen: got %b want 1", RX_BUSY); end
        UART_RX = 1'b1;
        #(BIT_NS);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL glitch_state: got %s want IDLE", dbg_state.name()); end
        total++; if (rx_if.RX_LEVEL !== 5'd0 || FRAME_ERR !== 1'b0) begin bad++; $display("FAIL glitch_effect: got lvl=%0d ferr=%b want 0/0", rx_if.RX_LEVEL, FRAME_ERR); end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        #(2 * BIT_NS);
        total++; if (FRAME_ERR !== exp_frame_err) begin bad++; $display("FAIL ferr_set: got %b want %b", FRAME_ERR, exp_frame_err); end
        total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size())) begin bad++; $display("FAIL ferr_no_push: got %0d want %0d", rx_if.RX_LEVEL, exp_q.size()); end
        pulse_err_clr();
        total++; if (FRAME_ERR !== exp_frame_err) begin bad++; $display("FAIL ferr_clear: got %b want %b", FRAME_ERR, exp_frame_err); end
    endtask

    task automatic test_break();
        logic [7:0] d;
        logic v;
        UART_RX = 1'b0;
        #(15 * BIT_NS);
        total++; if (FRAME_ERR !== 1'b1 || dbg_state !== WAIT_IDLE) begin bad++; $display("FAIL break_first: got %b/%s want 1/WAIT_IDLE", FRAME_ERR, dbg_state.name()); end
        pulse_err_clr();
        #(15 * BIT_NS);
        total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL break_single_err: got %b want 0", FRAME_ERR); end
        UART_RX = 1'b1;
        #(2 * BIT_NS);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL break_release: got %s want IDLE", dbg_state.name()); end
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1);
        @(negedge CLK);
        pop_byte(d, v);
        total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL break_resume: got %b/%h want 1/%h", v, d, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_overrun();
        logic ok1;
        logic [7:0] d;
        logic v;
        rx_if.RX_READY = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        @(negedge CLK);
        total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size())) begin bad++; $display("FAIL ovr_level: got %0d want %0d", rx_if.RX_LEVEL, exp_q.size()); end
        total++; if (OVERRUN !== exp_overrun) begin bad++; $display("FAIL ovr_flag: got %b want %b", OVERRUN, exp_overrun); end
        total++; if (rx_if.RX_DATA !== exp_q[0]) begin bad++; $display("FAIL ovr_head: got %h want %h", rx_if.RX_DATA, exp_q[0]); end
        pulse_err_clr();
        total++; if (OVERRUN !== exp_overrun) begin bad++; $display("FAIL ovr_clear: got %b want %b", OVERRUN, exp_overrun); end
        // The stop sample lands 16 ticks after STOP is entered; pop exactly in that cycle.
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_state(STOP, 1'b1, ok1);
                repeat (BIT_CLKS - 1) @(negedge CLK);
                rx_if.RX_READY = 1'b1;
                @(negedge CLK);
                rx_if.RX_READY = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        model_frame(8'h77, 1'b1);
        total++; if (!ok1) begin bad++; $display("FAIL ovr_stop_seen: got 0 want 1"); end
        total++; if (OVERRUN !== exp_overrun) begin bad++; $display("FAIL ovr_simul_flag: got %b want %b", OVERRUN, exp_overrun); end
        total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size()) || rx_if.RX_DATA !== exp_q[0]) begin bad++; $display("FAIL ovr_simul_state: got %0d/%h want %0d/%h", rx_if.RX_LEVEL, rx_if.RX_DATA, exp_q.size(), exp_q[0]); end
        while (exp_q.size() > 0) begin
            pop_byte(d, v);
            total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL ovr_drain: got %b/%h want 1/%h", v, d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h81;
        logic [7:0] d;
        logic v;
        send_frame(8'h99, 1'b1);
        model_frame(8'h99, 1'b1);
        UART_RX = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            UART_RX = b[i];
            #(BIT_NS);
        end
        UART_RX = b[4];
        #(BIT_NS / 2);
        @(negedge CLK);
        RST_N   = 1'b0;
        UART_RX = 1'b1;
        exp_q.delete();
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (rx_if.RX_LEVEL !== 5'd0 || rx_if.RX_VALID !== 1'b0 || RX_BUSY !== 1'b0) begin bad++; $display("FAIL midrst_clear: got %0d/%b/%b want 0/0/0", rx_if.RX_LEVEL, rx_if.RX_VALID, RX_BUSY); end
        RST_N = 1'b1;
        #(2 * BIT_NS);
        send_frame(8'h42, 1'b1);
        model_frame(8'h42, 1'b1);
        @(negedge CLK);
        total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size())) begin bad++; $display("FAIL midrst_level: got %0d want %0d", rx_if.RX_LEVEL, exp_q.size()); end
        total++; if ({FRAME_ERR, OVERRUN} !== {exp_frame_err, exp_overrun}) begin bad++; $display("FAIL midrst_flags: got %b%b want %b%b", FRAME_ERR, OVERRUN, exp_frame_err, exp_overrun); end
        pop_byte(d, v);
        total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL midrst_data: got %b/%h want 1/%h", v, d, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       good;
        logic [7:0] d;
        logic v;
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good);
            model_frame(b, good);
            #(2 * BIT_NS);
            total++; if (FRAME_ERR !== exp_frame_err) begin bad++; $display("FAIL rand_ferr: got %b want %b byte %h", FRAME_ERR, exp_frame_err, b); end
            total++; if (rx_if.RX_LEVEL !== 5'(exp_q.size())) begin bad++; $display("FAIL rand_level: got %0d want %0d", rx_if.RX_LEVEL, exp_q.size()); end
            if (!good) pulse_err_clr();
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
                pop_byte(d, v);
                total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL rand_pop: got %b/%h want 1/%h", v, d, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        while (exp_q.size() > 0) begin
            pop_byte(d, v);
            total++; if (v !== 1'b1 || d !== exp_q[0]) begin bad++; $display("FAIL rand_drain: got %b/%h want 1/%h", v, d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        @(negedge CLK);
        total++; if (rx_if.RX_VALID !== 1'b0) begin bad++; $display("FAIL rand_empty: got %b want 0", rx_if.RX_VALID); end
    endtask

    initial begin
        rx_if.RX_READY = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
